// File: rtl/sm3_msg_padder_if.sv
// rtl/sm3_msg_padder_if.sv - message-word stream in, padded-block stream out, status
interface sm3_msg_padder_if;
  logic [31:0]  msg_in;
  logic         msg_valid_in;
  logic         is_last_word_in;
  logic [1:0]   last_word_byte_in;
  logic         msg_ready_out;
  logic [511:0] block_out;
  logic         block_valid_out;
  logic         block_ready_in;
  logic         block_first_out;
  logic         block_last_out;
  logic         overflow_err_out;

  modport slave (
    input  msg_in, msg_valid_in, is_last_word_in, last_word_byte_in, block_ready_in,
    output msg_ready_out, block_out, block_valid_out, block_first_out, block_last_out,
           overflow_err_out
  );

  modport master (
    output msg_in, msg_valid_in, is_last_word_in, last_word_byte_in, block_ready_in,
    input  msg_ready_out, block_out, block_valid_out, block_first_out, block_last_out,
           overflow_err_out
  );
endinterface

// File: rtl/sm3_msg_padder.sv
// rtl/sm3_msg_padder.sv - SM3 padder: 32-bit words in, padded 512-bit blocks out
module sm3_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  sm3_msg_padder_if.slave bus
);
  typedef enum logic [2:0] {ST_ACCEPT, ST_PAD, ST_LEN, ST_EXTRA, ST_EMIT} state_t;

  state_t           state_q, state_d, pend_q, pend_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             need80_q, need80_d;
  logic             fits_q, fits_d;
  logic [31:0]      buf_q [16];
  logic [31:0]      buf_d [16];
  logic             msg_ready_q, msg_ready_d;
  logic             block_valid_q, block_valid_d;
  logic             block_first_q, block_first_d;
  logic             block_last_q, block_last_d;
  logic             overflow_q, overflow_d;

  logic             wr_en;
  logic [31:0]      wr_word;
  logic             emit, emit_last;
  state_t           emit_pend;
  logic             fits_now;
  logic [63:0]      len64;
  logic [5:0]       last_bits;
  logic [511:0]     block;

  assign len64     = 64'(len_q);
  assign last_bits = {1'b0, bus.last_word_byte_in, 3'b000} + 6'd8;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    widx_d        = widx_q;
    len_d         = len_q;
    first_d       = first_q;
    need80_d      = need80_q;
    fits_d        = fits_q;
    buf_d         = buf_q;
    block_valid_d = block_valid_q;
    block_first_d = block_first_q;
    block_last_d  = block_last_q;
    wr_en         = 1'b0;
    wr_word       = '0;
    emit          = 1'b0;
    emit_last     = 1'b0;
    emit_pend     = ST_ACCEPT;
    fits_now      = fits_q;
    overflow_d    = overflow_q | (bus.msg_valid_in & ~msg_ready_q);

    case (state_q)
      ST_ACCEPT: begin
        if (bus.msg_valid_in && msg_ready_q) begin
          wr_en = 1'b1;
          if (!bus.is_last_word_in) begin
            wr_word = bus.msg_in;
            len_d   = len_q + LEN_W'(32);
            if (widx_q == 4'd15) begin
              emit      = 1'b1;
              emit_pend = ST_ACCEPT;
            end
          end else begin
            len_d = len_q + LEN_W'(last_bits);
            case (bus.last_word_byte_in)
              2'd0:    wr_word = {bus.msg_in[31:24], 8'h80, 16'h0000};
              2'd1:    wr_word = {bus.msg_in[31:16], 8'h80, 8'h00};
              2'd2:    wr_word = {bus.msg_in[31:8], 8'h80};
              default: wr_word = bus.msg_in;
            endcase
            if (bus.last_word_byte_in == 2'd3) begin
              // Full last word: the 0x80 marker becomes the following write.
              need80_d = 1'b1;
              if (widx_q == 4'd15) begin
                emit      = 1'b1;
                emit_pend = ST_PAD;
              end else begin
                state_d = ST_PAD;
              end
            end else begin
              fits_d = (widx_q <= 4'd13);
              if (widx_q == 4'd15) begin
                emit      = 1'b1;
                emit_pend = ST_EXTRA;
              end else if (widx_q == 4'd13) begin
                state_d = ST_LEN;
              end else begin
                state_d = ST_PAD;
              end
            end
          end
        end
      end
      ST_PAD: begin
        wr_en    = 1'b1;
        wr_word  = need80_q ? 32'h8000_0000 : 32'h0;
        need80_d = 1'b0;
        fits_now = need80_q ? (widx_q <= 4'd13) : fits_q;
        fits_d   = fits_now;
        if (fits_now && widx_q == 4'd13) begin
          state_d = ST_LEN;
        end else if (widx_q == 4'd15) begin
          emit      = 1'b1;
          emit_pend = ST_EXTRA;
        end
      end
      ST_LEN: begin
        wr_en   = 1'b1;
        wr_word = (widx_q == 4'd14) ? len64[63:32] : len64[31:0];
        if (widx_q == 4'd15) begin
          emit      = 1'b1;
          emit_last = 1'b1;
        end
      end
      ST_EXTRA: begin
        wr_en = 1'b1;
        if (widx_q == 4'd14)      wr_word = len64[63:32];
        else if (widx_q == 4'd15) wr_word = len64[31:0];
        else                      wr_word = 32'h0;
        if (widx_q == 4'd15) begin
          emit      = 1'b1;
          emit_last = 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.block_ready_in) begin
          block_valid_d = 1'b0;
          block_first_d = 1'b0;
          block_last_d  = 1'b0;
          if (block_last_q) begin
            state_d = ST_ACCEPT;
            len_d   = '0;
            first_d = 1'b1;
          end else begin
            state_d = pend_q;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    if (wr_en) begin
      buf_d[widx_q] = wr_word;
      widx_d        = widx_q + 4'd1;
    end

    if (emit) begin
      state_d       = ST_EMIT;
      pend_d        = emit_pend;
      block_valid_d = 1'b1;
      block_first_d = first_q;
      block_last_d  = emit_last;
    end

    msg_ready_d = (state_d == ST_ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACCEPT;
      pend_q        <= ST_ACCEPT;
      widx_q        <= '0;
      len_q         <= '0;
      first_q       <= 1'b1;
      need80_q      <= 1'b0;
      fits_q        <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      msg_ready_q   <= 1'b0;
      block_valid_q <= 1'b0;
      block_first_q <= 1'b0;
      block_last_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      widx_q        <= widx_d;
      len_q         <= len_d;
      first_q       <= first_d;
      need80_q      <= need80_d;
      fits_q        <= fits_d;
      buf_q         <= buf_d;
      msg_ready_q   <= msg_ready_d;
      block_valid_q <= block_valid_d;
      block_first_q <= block_first_d;
      block_last_q  <= block_last_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    block = '0;
    for (int i = 0; i < 16; i++) block[511-32*i -: 32] = buf_q[i];
  end

  assign bus.block_out        = block;
  assign bus.msg_ready_out    = msg_ready_q;
  assign bus.block_valid_out  = block_valid_q;
  assign bus.block_first_out  = block_first_q;
  assign bus.block_last_out   = block_last_q;
  assign bus.overflow_err_out = overflow_q;
endmodule

// File: tb/tb_sm3_msg_padder.sv
// tb/tb_sm3_msg_padder.sv - scoreboard bench for sm3_msg_padder against a byte-level SM3 padding model
module tb_sm3_msg_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm3_msg_padder_if bus();
  sm3_msg_padder #(.LEN_W(64)) dut (.clk(clk), .reset(rst), .bus(bus.slave));

  typedef struct {
    logic [511:0] data;
    bit           first;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected blocks straight from the padding rule: msg || 0x80 || 0* || 64-bit bit length.
  task automatic push_expected(input byte unsigned m[$]);
    byte unsigned    p[$];
    longint unsigned bits;
    exp_t            e;
    int              nb;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[b*64+j];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.block_valid_out && bus.block_ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", {511'b0, bus.block_valid_out}, 512'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("block_data", bus.block_out, mon_e.data);
        chk("block_first", {511'b0, bus.block_first_out}, {511'b0, mon_e.first});
        chk("block_last", {511'b0, bus.block_last_out}, {511'b0, mon_e.last});
      end
    end
  end

  initial begin
    bus.block_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.block_ready_in = stall ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  task automatic send_word(input logic [31:0] w, input bit last, input logic [1:0] lwb);
    int n = 0;
    @(negedge clk);
    while (!bus.msg_ready_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.msg_ready_out) begin
      chk("ready_timeout", {511'b0, bus.msg_ready_out}, 512'd1);
      return;
    end
    bus.msg_in            = w;
    bus.msg_valid_in      = 1'b1;
    bus.is_last_word_in   = last;
    bus.last_word_byte_in = lwb;
    @(posedge clk);
    #1;
    bus.msg_valid_in = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic send_msg(input byte unsigned m[$], input bit gaps);
    int          n;
    int          nw;
    logic [31:0] w;
    bit          last;
    push_expected(m);
    n  = m.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < n) w[31-8*b -: 8] = m[4*k+b];
      last = (k == nw - 1);
      if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
      send_word(w, last, last ? 2'((n - 1) % 4) : 2'($urandom_range(3)));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.block_valid_out) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 512'(exp_q.size()), 512'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.block_valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {511'b0, bus.block_valid_out}, 512'd0);
    chk("rst_ready", {511'b0, bus.msg_ready_out}, 512'd0);
    chk("rst_first", {511'b0, bus.block_first_out}, 512'd0);
    chk("rst_last", {511'b0, bus.block_last_out}, 512'd0);
    chk("rst_overflow", {511'b0, bus.overflow_err_out}, 512'd0);
    chk("rst_block", bus.block_out, 512'd0);
    rst = 1'b0;
  endtask

  function automatic void fill_abcd(ref byte unsigned m[$], input int n);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'(8'h61 + (i % 4)));
  endfunction

  initial begin
    byte unsigned m[$];
    logic [511:0] snap;

    bus.msg_in            = '0;
    bus.msg_valid_in      = 1'b0;
    bus.is_last_word_in   = 1'b0;
    bus.last_word_byte_in = '0;

    do_reset();

    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_valid();
    chk("abc_latency", 512'(cyc - acc_cyc), 512'd15);
    drain("drain_abc");

    m = '{8'h61};
    send_msg(m, 1'b0);
    drain("drain_one_byte");

    fill_abcd(m, 64);
    send_msg(m, 1'b0);
    drain("drain_64_bytes");

    fill_abcd(m, 56);
    send_msg(m, 1'b0);
    drain("drain_56_bytes");

    foreach (m[i]) m[i] = 8'($urandom);
    for (int len = 52; len <= 64; len += 3) begin
      fill_abcd(m, len);
      foreach (m[i]) m[i] = 8'($urandom);
      send_msg(m, 1'b1);
    end
    drain("drain_boundary");

    stall = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_valid();
    @(negedge clk);
    snap = bus.block_out;
    repeat (5) begin
      @(negedge clk);
      chk("stall_block_stable", bus.block_out, snap);
      chk("stall_valid_held", {511'b0, bus.block_valid_out}, 512'd1);
      chk("stall_ready_low", {511'b0, bus.msg_ready_out}, 512'd0);
    end
    bus.msg_in          = $urandom;
    bus.msg_valid_in    = 1'b1;
    bus.is_last_word_in = 1'b0;
    @(posedge clk);
    #1;
    bus.msg_valid_in = 1'b0;
    @(negedge clk);
    chk("overflow_set", {511'b0, bus.overflow_err_out}, 512'd1);
    stall = 1'b0;
    drain("drain_stall");
    chk("overflow_sticky", {511'b0, bus.overflow_err_out}, 512'd1);

    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 2'd0);
    do_reset();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    drain("drain_after_reset");

    stall = 1'b1;
    send_msg(m, 1'b0);
    wait_valid();
    do_reset();
    exp_q.delete();
    stall = 1'b0;
    @(negedge clk);
    chk("emit_reset_valid", {511'b0, bus.block_valid_out}, 512'd0);
    send_msg(m, 1'b0);
    drain("drain_after_emit_reset");

    for (int t = 0; t < 25; t++) begin
      m.delete();
      repeat ($urandom_range(150, 1)) m.push_back(8'($urandom));
      send_msg(m, 1'b1);
    end
    drain("drain_random");
    chk("overflow_clear", {511'b0, bus.overflow_err_out}, 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
